pbit_weight_loader: RTL

- Upstream configuration stage for a p-bit array: accepts a serial stream of coupling weights (J) and biases (h) over a valid/ready handshake.
- Stores the stream in a per-p-bit register file and drives the parallel J_n0..J_n5 / h_n buses of every p-bit.
- Raises weight_load_DONE once the full array is written, which gates p-bit updates downstream.
- Reloadable at any time; a reload drops weight_load_DONE so the p-bits freeze while weights change.

---
 rtl/pbit_weight_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pbit_weight_loader.sv
// Serial-to-parallel loader for p-bit coupling weights (J) and biases (h).
// Optional macro WEIGHT_CHECKSUM_EN adds a trailing XOR checksum beat verified before DONE.
module pbit_weight_loader #(
  parameter int NUM_PBITS   = 16,
  parameter int NUM_NEIGH   = 6,
  parameter int J_BIT_WIDTH = 10,
  parameter int H_BIT_WIDTH = 10,
  parameter int DATA_W      = (J_BIT_WIDTH > H_BIT_WIDTH) ? J_BIT_WIDTH : H_BIT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load_start,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic [DATA_W-1:0]                        wr_data,
  output logic [NUM_PBITS*NUM_NEIGH*J_BIT_WIDTH-1:0] J_flat,
  output logic [NUM_PBITS*H_BIT_WIDTH-1:0]         h_flat,
  output logic                                     weight_load_DONE,
  output logic                                     load_busy,
  output logic                                     load_err
);

  localparam int PW = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;

`ifdef WEIGHT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [2:0]      slot_q, slot_d;
  logic [PW-1:0]   pbit_q, pbit_d;
  logic            load_err_q, load_err_d;
  logic            wr_ready_q, load_busy_q, done_q;
  logic            ready_d;
  logic            we;
  logic            accept;

  assign accept = wr_valid && wr_ready_q;

`ifdef WEIGHT_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q, xor_d;
`endif

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    pbit_d     = pbit_q;
    load_err_d = load_err_q;
    we         = 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    if (load_start) begin
      // A start pulse always (re)opens a load and discards any beat in the same cycle.
      state_d    = LOAD;
      slot_d     = '0;
      pbit_d     = '0;
      load_err_d = 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
      xor_d      = '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            we = 1'b1;
`ifdef WEIGHT_CHECKSUM_EN
            xor_d = xor_q ^ wr_data;
`endif
            if (slot_q == 3'(NUM_NEIGH)) begin
              slot_d = '0;
              if (pbit_q == PW'(NUM_PBITS - 1)) begin
                pbit_d  = '0;
`ifdef WEIGHT_CHECKSUM_EN
                state_d = CHECK;
`else
                state_d = DONE;
`endif
              end else begin
                pbit_d = pbit_q + 1'b1;
              end
            end else begin
              slot_d = slot_q + 3'd1;
            end
          end
        end
`ifdef WEIGHT_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (wr_data == xor_q) begin
              state_d = DONE;
            end else begin
              state_d    = IDLE;
              load_err_d = 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (wr_valid) load_err_d = 1'b1;
        end
        default: ;
      endcase
    end
    ready_d = (state_d == LOAD);
`ifdef WEIGHT_CHECKSUM_EN
    ready_d = ready_d || (state_d == CHECK);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      pbit_q      <= '0;
      load_err_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      load_busy_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pbit_q      <= pbit_d;
      load_err_q  <= load_err_d;
      wr_ready_q  <= ready_d;
      load_busy_q <= ready_d;
      done_q      <= (state_d == DONE);
    end
  end

`ifdef WEIGHT_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xor_q <= '0;
    else     xor_q <= xor_d;
  end
`endif

  assign wr_ready         = wr_ready_q;
  assign load_busy        = load_busy_q;
  assign weight_load_DONE = done_q;
  assign load_err         = load_err_q;

  // Register file: slots 0..NUM_NEIGH-1 hold J, slot NUM_NEIGH holds h.
  for (genvar gi = 0; gi < NUM_PBITS; gi++) begin : g_pbit
    for (genvar gn = 0; gn < NUM_NEIGH; gn++) begin : g_j
      logic [J_BIT_WIDTH-1:0] j_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          j_q <= '0;
        else if (we && pbit_q == PW'(gi) && slot_q == 3'(gn))
          j_q <= wr_data[J_BIT_WIDTH-1:0];
      end
      assign J_flat[(gi*NUM_NEIGH+gn)*J_BIT_WIDTH +: J_BIT_WIDTH] = j_q;
    end
    logic [H_BIT_WIDTH-1:0] h_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        h_q <= '0;
      else if (we && pbit_q == PW'(gi) && slot_q == 3'(NUM_NEIGH))
        h_q <= wr_data[H_BIT_WIDTH-1:0];
    end
    assign h_flat[gi*H_BIT_WIDTH +: H_BIT_WIDTH] = h_q;
  end

endmodule
